// File: rtl/flapjack_console_pkg.sv
// Shared types and character codes for the flapjack text console.
// The ESC cursor-addressing states are only reachable with FLAPJACK_CONSOLE_ESC_EN.
package flapjack_console_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CLRLINE,
        CLRSCR,
        ESC1,
        ESC_ROW,
        ESC_COL
    } state_t;

    typedef logic [6:0] col_t;
    typedef logic [5:0] row_t;

    localparam logic [7:0] CH_SPACE = 8'h20;
    localparam logic [7:0] CH_TILDE = 8'h7E;
    localparam logic [7:0] CH_BS    = 8'h08;
    localparam logic [7:0] CH_LF    = 8'h0A;
    localparam logic [7:0] CH_FF    = 8'h0C;
    localparam logic [7:0] CH_CR    = 8'h0D;
    localparam logic [7:0] CH_ESC   = 8'h1B;
    localparam logic [7:0] CH_Y     = 8'h59;

    localparam logic [8:0] CHR_BLANK = 9'h020;

endpackage

// File: rtl/flapjack_console.sv
// Byte-stream text console driving the vga_textmode write port.
// Define FLAPJACK_CONSOLE_ESC_EN to enable ESC 'Y' row col cursor addressing.
module flapjack_console
    import flapjack_console_pkg::*;
#(
    parameter int COLS = 80,
    parameter int ROWS = 30
) (
    input  logic       clk_sys,
    input  logic       reset,
    input  logic [7:0] in_data,
    input  logic       in_attr,
    input  logic       in_valid,
    output logic       in_ready,
    output logic [6:0] char_x,
    output logic [5:0] char_y,
    output logic [8:0] char_chr,
    output logic       char_str,
    output logic [6:0] cursor_x,
    output logic [5:0] cursor_y,
    output logic       busy
);

    localparam col_t COL_MAX = col_t'(COLS - 1);
    localparam row_t ROW_MAX = row_t'(ROWS - 1);

    state_t     state_q, state_d;
    col_t       cur_x_q, cur_x_d;
    row_t       cur_y_q, cur_y_d;
    col_t       sw_x_q, sw_x_d;
    row_t       sw_y_q, sw_y_d;
    row_t       row_lat_q, row_lat_d;
    col_t       char_x_q, char_x_d;
    row_t       char_y_q, char_y_d;
    logic [8:0] char_chr_q, char_chr_d;
    logic       char_str_q, char_str_d;
    logic       busy_q, busy_d;

    logic       xfer;
    logic       printable;
    row_t       y_next;

`ifdef FLAPJACK_CONSOLE_ESC_EN
    // ESC arguments are offset by 0x20; anything below that clamps to 0.
    function automatic logic [7:0] esc_off(input logic [7:0] b);
        return (b < CH_SPACE) ? 8'd0 : b - CH_SPACE;
    endfunction

    function automatic row_t clamp_row(input logic [7:0] b);
        logic [7:0] off;
        off = esc_off(b);
        return (off > 8'(ROWS - 1)) ? ROW_MAX : off[5:0];
    endfunction

    function automatic col_t clamp_col(input logic [7:0] b);
        logic [7:0] off;
        off = esc_off(b);
        return (off > 8'(COLS - 1)) ? COL_MAX : off[6:0];
    endfunction
`endif

    assign in_ready  = (state_q == IDLE) || (state_q == ESC1) ||
                       (state_q == ESC_ROW) || (state_q == ESC_COL);
    assign xfer      = in_valid && in_ready;
    assign printable = (in_data >= CH_SPACE) && (in_data <= CH_TILDE);
    assign y_next    = (cur_y_q == ROW_MAX) ? '0 : cur_y_q + row_t'(1);

    always_comb begin
        state_d    = state_q;
        cur_x_d    = cur_x_q;
        cur_y_d    = cur_y_q;
        sw_x_d     = sw_x_q;
        sw_y_d     = sw_y_q;
        row_lat_d  = row_lat_q;
        char_x_d   = char_x_q;
        char_y_d   = char_y_q;
        char_chr_d = char_chr_q;
        char_str_d = 1'b0;
        busy_d     = busy_q;
        unique case (state_q)
            IDLE: begin
                if (xfer && printable) begin
                    char_x_d   = cur_x_q;
                    char_y_d   = cur_y_q;
                    char_chr_d = {in_attr, in_data};
                    char_str_d = 1'b1;
                    if (cur_x_q == COL_MAX) begin
                        cur_x_d = '0;
                        cur_y_d = y_next;
                        sw_x_d  = '0;
                        state_d = CLRLINE;
                        busy_d  = 1'b1;
                    end else begin
                        cur_x_d = cur_x_q + col_t'(1);
                    end
                end else if (xfer) begin
                    unique case (in_data)
                        CH_LF: begin
                            cur_x_d = '0;
                            cur_y_d = y_next;
                            sw_x_d  = '0;
                            state_d = CLRLINE;
                            busy_d  = 1'b1;
                        end
                        CH_CR: cur_x_d = '0;
                        CH_BS: begin
                            if (cur_x_q != '0) begin
                                cur_x_d    = cur_x_q - col_t'(1);
                                char_x_d   = cur_x_q - col_t'(1);
                                char_y_d   = cur_y_q;
                                char_chr_d = CHR_BLANK;
                                char_str_d = 1'b1;
                            end
                        end
                        CH_FF: begin
                            cur_x_d = '0;
                            cur_y_d = '0;
                            sw_x_d  = '0;
                            sw_y_d  = '0;
                            state_d = CLRSCR;
                            busy_d  = 1'b1;
                        end
`ifdef FLAPJACK_CONSOLE_ESC_EN
                        CH_ESC: state_d = ESC1;
`endif
                        default: ;
                    endcase
                end
            end
            CLRLINE: begin
                char_x_d   = sw_x_q;
                char_y_d   = cur_y_q;
                char_chr_d = CHR_BLANK;
                char_str_d = 1'b1;
                if (sw_x_q == COL_MAX) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                end else begin
                    sw_x_d = sw_x_q + col_t'(1);
                end
            end
            CLRSCR: begin
                char_x_d   = sw_x_q;
                char_y_d   = sw_y_q;
                char_chr_d = CHR_BLANK;
                char_str_d = 1'b1;
                if (sw_x_q == COL_MAX) begin
                    sw_x_d = '0;
                    if (sw_y_q == ROW_MAX) begin
                        state_d = IDLE;
                        busy_d  = 1'b0;
                    end else begin
                        sw_y_d = sw_y_q + row_t'(1);
                    end
                end else begin
                    sw_x_d = sw_x_q + col_t'(1);
                end
            end
`ifdef FLAPJACK_CONSOLE_ESC_EN
            ESC1: begin
                if (xfer) state_d = (in_data == CH_Y) ? ESC_ROW : IDLE;
            end
            ESC_ROW: begin
                if (xfer) begin
                    row_lat_d = clamp_row(in_data);
                    state_d   = ESC_COL;
                end
            end
            ESC_COL: begin
                if (xfer) begin
                    cur_x_d = clamp_col(in_data);
                    cur_y_d = row_lat_q;
                    state_d = IDLE;
                end
            end
`endif
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state_q    <= IDLE;
            cur_x_q    <= '0;
            cur_y_q    <= '0;
            sw_x_q     <= '0;
            sw_y_q     <= '0;
            row_lat_q  <= '0;
            char_x_q   <= '0;
            char_y_q   <= '0;
            char_chr_q <= '0;
            char_str_q <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cur_x_q    <= cur_x_d;
            cur_y_q    <= cur_y_d;
            sw_x_q     <= sw_x_d;
            sw_y_q     <= sw_y_d;
            row_lat_q  <= row_lat_d;
            char_x_q   <= char_x_d;
            char_y_q   <= char_y_d;
            char_chr_q <= char_chr_d;
            char_str_q <= char_str_d;
            busy_q     <= busy_d;
        end
    end

    assign char_x   = char_x_q;
    assign char_y   = char_y_q;
    assign char_chr = char_chr_q;
    assign char_str = char_str_q;
    assign cursor_x = cur_x_q;
    assign cursor_y = cur_y_q;
    assign busy     = busy_q;

endmodule
